cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have req_valid in 3: per-source completion request; bit0 ALU, bit1 branch, bit2 mem.
REQ-003 SHALL have req_ready out 3: per-source buffer can accept.
REQ-004 SHALL have req_preg in 21: 3x7 destination physical register, source i at [7i+6:7i].
REQ-005 SHALL have req_data in 96: 3x32 result, source i at [32i+31:32i].
REQ-006 SHALL have req_rob_tag in 15: 3x5 ROB tag, source i at [5i+4:5i].
REQ-007 SHALL have rob_head in 5: oldest ROB tag.
REQ-008 SHALL have mispredict in 1 and mispredict_tag in 5: branch squash request.
REQ-009 SHALL have cdb_valid out 1, cdb_preg out 7, cdb_data out 32, cdb_rob_tag out 5, cdb_src out 2: the single shared writeback port.

Function
REQ-010 SHALL hold one 2-entry FIFO per source; entry = {live, preg, rob_tag, data}.
REQ-011 SHALL set req_ready[i] = (count_i < 2), registered-state only, with no combinational path from req_valid.
REQ-012 SHALL push on req_valid[i] && req_ready[i] at the clock edge.
REQ-013 SHALL mark a source eligible when its head entry is live.
REQ-014 SHALL pop one dead head entry per source per cycle without using the CDB slot.
REQ-015 SHALL grant at most one eligible source per cycle, round-robin: search starts at rr_ptr, then rr_ptr+1 mod 3.
REQ-016 SHALL set rr_ptr to (winner+1) mod 3 after a grant; rr_ptr is unchanged when there is no grant.
REQ-017 SHALL, at the edge, pop the winner's head and load {1, preg, data, rob_tag, src} into the cdb register; with no winner, cdb_valid is 0 and the payload holds.
REQ-018 SHALL give a latency of exactly 2 cycles: a request accepted in cycle N appears on cdb in cycle N+2 when uncontended.
REQ-019 SHALL allow push and pop on the same source in the same cycle; count is unchanged and ordering is preserved.
REQ-020 SHALL define age(t) = (t - rob_head) mod 32; an entry is younger than the branch iff age(t) > age(mispredict_tag).
REQ-021 SHALL, on mispredict, in the same edge, clear live on all younger FIFO entries, suppress pushes of younger incoming requests, and clear a younger cdb register load.
REQ-022 SHALL never squash an entry whose tag equals mispredict_tag.
REQ-023 SHALL exclude entries killed in the current cycle from that cycle's grant.
REQ-024 SHALL free squashed entries only via REQ-014 (at most one per source per cycle); req_ready reflects this.

Reset
REQ-025 SHALL on reset: all counts 0, all live 0, rr_ptr 0, cdb_valid 0, cdb_preg/cdb_data/cdb_rob_tag/cdb_src 0, req_ready 3'b111 in the next cycle.
REQ-026 SHALL give reset priority over push, pop and mispredict in the same cycle, discarding any in-flight entry.

Configuration
REQ-027 SHALL support the macro CDB_BRANCH_PRIORITY_EN. When defined, an eligible branch source (bit1) always wins and rr_ptr is not updated on a branch grant. When undefined, pure round-robin per REQ-015.

Verification
REQ-028 SHALL cover this scenario: after reset, single ALU request preg=5, data=0x1234, tag=3 in cycle 1 -> cdb_valid=1, preg=5, data=0x1234, rob_tag=3, src=0 in cycle 3 only.
REQ-029 SHALL cover this scenario: all three sources request every cycle for 6 cycles -> cdb_src sequence 0,1,2,0,1,2; CDB_BRANCH_PRIORITY_EN build -> 1,1,1,... until the branch source stalls.
REQ-030 SHALL cover this scenario: hold ALU source with no grants by using priority build and continuous branch traffic, ALU FIFO fills -> req_ready[0]=0 after 2 accepts; third request is held and accepted only after a pop.
REQ-031 SHALL cover this scenario: rob_head=30, mem FIFO tags {1,31}, mispredict_tag=0 -> tag 1 squashed and never on cdb; tag 31 delivered; tag 0 branch result delivered.
REQ-032 SHALL cover this scenario: cdb register loaded with tag 7, rob_head=4, mispredict_tag=5 in the same edge -> cdb_valid=0 next cycle.
REQ-033 SHALL cover this scenario: reset asserted with both FIFOs full and cdb_valid=1 -> next cycle cdb_valid=0, req_ready=3'b111, no stale entry ever emitted.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Three completion sources (ALU,
//               branch, mem) each feed a 2-entry FIFO. One live head entry
//               per cycle wins the shared writeback port by round-robin.
//               A branch mispredict squashes younger entries in place. Dead
//               heads drain one per source per cycle without using the bus.
//               Optional macro CDB_BRANCH_PRIORITY_EN: an eligible branch
//               source always wins and does not advance the round-robin
//               pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   req_valid,
  output logic [2:0]   req_ready,
  input  logic [20:0]  req_preg,
  input  logic [95:0]  req_data,
  input  logic [14:0]  req_rob_tag,
  input  logic [4:0]   rob_head,
  input  logic         mispredict,
  input  logic [4:0]   mispredict_tag,
  output logic         cdb_valid,
  output logic [6:0]   cdb_preg,
  output logic [31:0]  cdb_data,
  output logic [4:0]   cdb_rob_tag,
  output logic [1:0]   cdb_src
);

  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 2;

  // Age is measured relative to the ROB head so that tag wrap-around is
  // handled; an entry is younger than the branch when it is strictly
  // further from the head. The branch's own tag is never younger.
  function automatic logic is_younger(input logic [4:0] tag,
                                      input logic [4:0] head,
                                      input logic [4:0] br_tag);
    logic [4:0] age_tag;
    logic [4:0] age_br;
    age_tag = tag - head;
    age_br  = br_tag - head;
    return age_tag > age_br;
  endfunction

  // Source index increment modulo 3.
  function automatic logic [1:0] next_src(input logic [1:0] src);
    return (src == 2'd2) ? 2'd0 : src + 2'd1;
  endfunction

  // Per-source FIFO state. Squashed entries stay resident with live=0
  // until they reach the head and are drained.
  logic [1:0]  count_q  [NUM_SRC];
  logic        rd_ptr_q [NUM_SRC];
  logic        wr_ptr_q [NUM_SRC];
  logic        live_q   [NUM_SRC][DEPTH];
  logic [6:0]  preg_q   [NUM_SRC][DEPTH];
  logic [4:0]  tag_q    [NUM_SRC][DEPTH];
  logic [31:0] data_q   [NUM_SRC][DEPTH];
  logic [1:0]  rr_ptr_q;

  logic [NUM_SRC-1:0] head_live;
  logic [NUM_SRC-1:0] head_dead;
  logic [NUM_SRC-1:0] head_killed;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic        grant_found;
  logic [1:0]  winner;
  logic        rr_advance;
  logic [1:0]  rr_idx;
  logic [6:0]  win_preg;
  logic [4:0]  win_tag;
  logic [31:0] win_data;

  // Per-source status: ready from registered count only, head liveness,
  // same-cycle squash of the head, and push filtering of younger arrivals.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_ready[i]   = (count_q[i] < 2'd2);
      head_live[i]   = (count_q[i] != 2'd0) && live_q[i][rd_ptr_q[i]];
      head_dead[i]   = (count_q[i] != 2'd0) && !live_q[i][rd_ptr_q[i]];
      head_killed[i] = mispredict &&
                       is_younger(tag_q[i][rd_ptr_q[i]], rob_head, mispredict_tag);
      eligible[i]    = head_live[i] && !head_killed[i];
      push[i]        = req_valid[i] && req_ready[i] &&
                       !(mispredict &&
                         is_younger(req_rob_tag[5*i +: 5], rob_head, mispredict_tag));
    end
  end

  // Round-robin search starting at rr_ptr; optional branch override.
  always_comb begin
    grant_found = 1'b0;
    winner      = 2'd0;
    rr_idx      = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_found && eligible[rr_idx]) begin
        grant_found = 1'b1;
        winner      = rr_idx;
      end
      rr_idx = next_src(rr_idx);
    end
    rr_advance = grant_found;
`ifdef CDB_BRANCH_PRIORITY_EN
    if (eligible[1]) begin
      grant_found = 1'b1;
      winner      = 2'd1;
      rr_advance  = 1'b0;
    end
`endif
  end

  // Pop selection and winner payload mux. A granted head is always live,
  // so a granted pop and a dead-head drain never coincide on one source.
  always_comb begin
    win_preg = '0;
    win_tag  = '0;
    win_data = '0;
    pop      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = head_dead[i] || (grant_found && (winner == 2'(i)));
      if (grant_found && (winner == 2'(i))) begin
        win_preg = preg_q[i][rd_ptr_q[i]];
        win_tag  = tag_q[i][rd_ptr_q[i]];
        win_data = data_q[i][rd_ptr_q[i]];
      end
    end
  end

  // FIFO control: squash, push, pop and occupancy; reset discards all.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i]  <= 2'd0;
        rd_ptr_q[i] <= 1'b0;
        wr_ptr_q[i] <= 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
          live_q[i][e] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (mispredict && is_younger(tag_q[i][e], rob_head, mispredict_tag)) begin
            live_q[i][e] <= 1'b0;
          end
        end
        // The push slot is always free, so this never overrides a squash
        // of a resident entry.
        if (push[i]) begin
          live_q[i][wr_ptr_q[i]] <= 1'b1;
          wr_ptr_q[i]            <= ~wr_ptr_q[i];
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= ~rd_ptr_q[i];
        end
        count_q[i] <= count_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end
  end

  // FIFO payload storage; contents are qualified by count and live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        preg_q[i][wr_ptr_q[i]] <= req_preg[7*i +: 7];
        tag_q[i][wr_ptr_q[i]]  <= req_rob_tag[5*i +: 5];
        data_q[i][wr_ptr_q[i]] <= req_data[32*i +: 32];
      end
    end
  end

  // Round-robin pointer moves past the winner only on a counted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 2'd0;
    end else if (rr_advance) begin
      rr_ptr_q <= next_src(winner);
    end
  end

  // CDB register: a killed head never wins, so a younger load is dropped
  // in the same edge as the mispredict. Payload holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_preg    <= '0;
      cdb_data    <= '0;
      cdb_rob_tag <= '0;
      cdb_src     <= '0;
    end else begin
      cdb_valid <= grant_found;
      if (grant_found) begin
        cdb_preg    <= win_preg;
        cdb_data    <= win_data;
        cdb_rob_tag <= win_tag;
        cdb_src     <= winner;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Scoreboard bench for cdb_arbiter. Expected CDB results are
//               queued per source when a request is accepted and compared
//               in order when cdb_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [20:0] req_preg;
  logic [95:0] req_data;
  logic [14:0] req_rob_tag;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        cdb_valid;
  logic [6:0]  cdb_preg;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_rob_tag;
  logic [1:0]  cdb_src;

  typedef struct packed {
    logic [6:0]  preg;
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sbq [3][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_preg       (req_preg),
    .req_data       (req_data),
    .req_rob_tag    (req_rob_tag),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .cdb_valid      (cdb_valid),
    .cdb_preg       (cdb_preg),
    .cdb_data       (cdb_data),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_src        (cdb_src)
  );

  function automatic exp_t mk(input int p, input int d, input int t);
    exp_t r;
    r.preg = 7'(p);
    r.data = 32'(d);
    r.tag  = 5'(t);
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int s, input exp_t e);
    req_valid[s]          = 1'b1;
    req_preg[7*s +: 7]    = e.preg;
    req_data[32*s +: 32]  = e.data;
    req_rob_tag[5*s +: 5] = e.tag;
  endtask

  task automatic apply_reset;
    reset          = 1'b1;
    req_valid      = 3'b000;
    mispredict     = 1'b0;
    mispredict_tag = 5'd0;
    rob_head       = 5'd0;
    step;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) sbq[s].delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid);
    end
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111", req_ready);
    end
    n_checks++;
    if ({cdb_preg, cdb_data, cdb_rob_tag, cdb_src} !== 46'd0) begin
      n_fail++; $display("FAIL reset_payload: got %h/%h/%h/%h want 0", cdb_preg, cdb_data, cdb_rob_tag, cdb_src);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    exp_t want;
    apply_reset;
    e = mk(5, 32'h1234, 3);
    drive_req(0, e);
    sbq[0].push_back(e);
    step;
    req_valid = 3'b000;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle2: cdb_valid got %b want 0", cdb_valid);
    end
    step;
    want = sbq[0].pop_front();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || {cdb_preg, cdb_data, cdb_rob_tag} !== want) begin
      n_fail++; $display("FAIL single_cycle3: got v=%b src=%0d preg=%0d data=%h tag=%0d want v=1 src=0 preg=%0d data=%h tag=%0d",
                         cdb_valid, cdb_src, cdb_preg, cdb_data, cdb_rob_tag, want.preg, want.data, want.tag);
    end
    step;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_cycle4: cdb_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_round_robin;
    int         sent [3];
    logic       acc [3];
    exp_t       it [3];
    exp_t       got;
    exp_t       want;
    int         n_out;
    logic [1:0] src_tab [6];
    logic [2:0] rdy_c3;
    logic [2:0] rdy_c4;
`ifdef CDB_BRANCH_PRIORITY_EN
    src_tab = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    rdy_c3  = 3'b010;
    rdy_c4  = 3'b010;
`else
    src_tab = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rdy_c3  = 3'b001;
    rdy_c4  = 3'b010;
`endif
    apply_reset;
    n_out = 0;
    for (int s = 0; s < 3; s++) sent[s] = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cdb_valid === 1'b1) begin
        n_checks++;
        if (cdb_src > 2'd2 || sbq[cdb_src].size() == 0) begin
          n_fail++; $display("FAIL rr_payload: unexpected output src=%0d tag=%0d", cdb_src, cdb_rob_tag);
        end else begin
          got  = {cdb_preg, cdb_data, cdb_rob_tag};
          want = sbq[cdb_src].pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL rr_payload: src=%0d got %h want %h", cdb_src, got, want);
          end
        end
        if (n_out < 6) begin
          n_checks++;
          if (cdb_src !== src_tab[n_out]) begin
            n_fail++; $display("FAIL rr_order: grant %0d got src %0d want %0d", n_out, cdb_src, src_tab[n_out]);
          end
        end
        n_out++;
      end
      if (cyc == 2) begin
        n_checks++;
        if (req_ready !== rdy_c3) begin
          n_fail++; $display("FAIL rr_ready_c3: got %b want %b", req_ready, rdy_c3);
        end
      end
      if (cyc == 3) begin
        n_checks++;
        if (req_ready !== rdy_c4) begin
          n_fail++; $display("FAIL rr_ready_c4: got %b want %b", req_ready, rdy_c4);
        end
      end
      for (int s = 0; s < 3; s++) begin
        if (cyc < 6) begin
          it[s] = mk(s*20 + sent[s], 32'hA000_0000 + s*256 + sent[s], s*8 + sent[s]);
          drive_req(s, it[s]);
          acc[s] = req_ready[s];
        end else begin
          req_valid[s] = 1'b0;
          acc[s]       = 1'b0;
        end
      end
      step;
      for (int s = 0; s < 3; s++) begin
        if (acc[s]) begin
          sbq[s].push_back(it[s]);
          sent[s]++;
        end
      end
    end
    n_checks++;
    if (sent[0] + sent[1] + sent[2] != 10) begin
      n_fail++; $display("FAIL rr_accepts: got %0d want 10", sent[0] + sent[1] + sent[2]);
    end
    n_checks++;
    if (n_out != 10) begin
      n_fail++; $display("FAIL rr_outputs: got %0d want 10", n_out);
    end
  endtask

`ifdef CDB_BRANCH_PRIORITY_EN
  task automatic test_alu_starve;
    int   sent [3];
    logic acc [3];
    exp_t it [3];
    exp_t got;
    exp_t want;
    apply_reset;
    for (int s = 0; s < 3; s++) sent[s] = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cdb_valid === 1'b1) begin
        n_checks++;
        if (cdb_src > 2'd2 || sbq[cdb_src].size() == 0) begin
          n_fail++; $display("FAIL starve_payload: unexpected output src=%0d tag=%0d", cdb_src, cdb_rob_tag);
        end else begin
          got  = {cdb_preg, cdb_data, cdb_rob_tag};
          want = sbq[cdb_src].pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL starve_payload: src=%0d got %h want %h", cdb_src, got, want);
          end
        end
      end
      if (cyc == 2 || cyc == 5) begin
        n_checks++;
        if (req_ready[0] !== 1'b0 || sent[0] != 2) begin
          n_fail++; $display("FAIL starve_full: cycle %0d ready0 got %b want 0, accepts got %0d want 2", cyc, req_ready[0], sent[0]);
        end
      end
      acc[2] = 1'b0;
      req_valid[2] = 1'b0;
      if (cyc < 8) begin
        it[1] = mk(40 + sent[1], 32'hB000 + sent[1], 8 + sent[1]);
        drive_req(1, it[1]);
        acc[1] = req_ready[1];
      end else begin
        req_valid[1] = 1'b0;
        acc[1] = 1'b0;
      end
      if (sent[0] < 3) begin
        it[0] = mk(60 + sent[0], 32'hA000 + sent[0], 20 + sent[0]);
        drive_req(0, it[0]);
        acc[0] = req_ready[0];
      end else begin
        req_valid[0] = 1'b0;
        acc[0] = 1'b0;
      end
      step;
      for (int s = 0; s < 3; s++) begin
        if (acc[s]) begin
          sbq[s].push_back(it[s]);
          sent[s]++;
        end
      end
    end
    n_checks++;
    if (sent[0] != 3) begin
      n_fail++; $display("FAIL starve_third: alu accepts got %0d want 3", sent[0]);
    end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (sbq[s].size() != 0) begin
        n_fail++; $display("FAIL starve_drain: src %0d left %0d want 0", s, sbq[s].size());
      end
    end
  endtask
`endif

  task automatic test_squash_wrap;
    exp_t b;
    exp_t m1;
    exp_t m2;
    exp_t got;
    exp_t want;
    int   n_out;
    apply_reset;
    rob_head = 5'd30;
    b  = mk(10, 32'hB0, 0);
    m1 = mk(11, 32'hC1, 1);
    m2 = mk(12, 32'hC31, 31);
    drive_req(1, b);
    drive_req(2, m1);
    sbq[1].push_back(b);
    step;
    req_valid[1]   = 1'b0;
    drive_req(2, m2);
    sbq[2].push_back(m2);
    mispredict     = 1'b1;
    mispredict_tag = 5'd0;
    step;
    mispredict = 1'b0;
    req_valid  = 3'b000;
    n_out = 0;
    for (int cyc = 3; cyc < 15; cyc++) begin
      if (cyc == 3) begin
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1) begin
          n_fail++; $display("FAIL squash_branch_c3: got v=%b src=%0d want v=1 src=1", cdb_valid, cdb_src);
        end
        n_checks++;
        if (req_ready !== 3'b011) begin
          n_fail++; $display("FAIL squash_ready_c3: got %b want 011", req_ready);
        end
      end
      if (cyc == 4) begin
        n_checks++;
        if (cdb_valid !== 1'b0) begin
          n_fail++; $display("FAIL squash_gap_c4: cdb_valid got %b want 0", cdb_valid);
        end
      end
      if (cyc == 5) begin
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2) begin
          n_fail++; $display("FAIL squash_mem_c5: got v=%b src=%0d want v=1 src=2", cdb_valid, cdb_src);
        end
      end
      if (cdb_valid === 1'b1) begin
        n_out++;
        n_checks++;
        if (cdb_src > 2'd2 || sbq[cdb_src].size() == 0) begin
          n_fail++; $display("FAIL squash_payload: unexpected output src=%0d tag=%0d", cdb_src, cdb_rob_tag);
        end else begin
          got  = {cdb_preg, cdb_data, cdb_rob_tag};
          want = sbq[cdb_src].pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL squash_payload: src=%0d got %h want %h", cdb_src, got, want);
          end
        end
      end
      step;
    end
    n_checks++;
    if (n_out != 2) begin
      n_fail++; $display("FAIL squash_count: outputs got %0d want 2", n_out);
    end
  endtask

  task automatic test_cdb_kill;
    exp_t bt;
    exp_t got;
    exp_t want;
    int   n_out;
    apply_reset;
    rob_head = 5'd4;
    drive_req(0, mk(20, 32'h77, 7));
    step;
    req_valid[0]   = 1'b0;
    mispredict     = 1'b1;
    mispredict_tag = 5'd5;
    drive_req(2, mk(21, 32'h99, 9));
    bt = mk(22, 32'h55, 5);
    drive_req(1, bt);
    sbq[1].push_back(bt);
    step;
    mispredict = 1'b0;
    req_valid  = 3'b000;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_cdb_c3: cdb_valid got %b want 0", cdb_valid);
    end
    step;
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_rob_tag !== 5'd5) begin
      n_fail++; $display("FAIL kill_equal_tag_c4: got v=%b src=%0d tag=%0d want v=1 src=1 tag=5", cdb_valid, cdb_src, cdb_rob_tag);
    end
    n_out = 0;
    for (int cyc = 4; cyc < 14; cyc++) begin
      if (cdb_valid === 1'b1) begin
        n_out++;
        n_checks++;
        if (cdb_src > 2'd2 || sbq[cdb_src].size() == 0) begin
          n_fail++; $display("FAIL kill_payload: unexpected output src=%0d tag=%0d", cdb_src, cdb_rob_tag);
        end else begin
          got  = {cdb_preg, cdb_data, cdb_rob_tag};
          want = sbq[cdb_src].pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL kill_payload: src=%0d got %h want %h", cdb_src, got, want);
          end
        end
      end
      step;
    end
    n_checks++;
    if (n_out != 1) begin
      n_fail++; $display("FAIL kill_count: outputs got %0d want 1", n_out);
    end
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++; $display("FAIL kill_ready_end: got %b want 111", req_ready);
    end
  endtask

  task automatic test_reset_flush;
    int n_out;
    apply_reset;
    drive_req(0, mk(1, 32'hF0, 1));
    drive_req(1, mk(2, 32'hF1, 2));
    drive_req(2, mk(3, 32'hF2, 3));
    step;
    step;
    n_checks++;
    if (cdb_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: cdb_valid got %b want 1", cdb_valid);
    end
    reset = 1'b1;
    step;
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", cdb_valid);
    end
    n_checks++;
    if (req_ready !== 3'b111) begin
      n_fail++; $display("FAIL flush_ready: got %b want 111", req_ready);
    end
    n_checks++;
    if ({cdb_preg, cdb_data, cdb_rob_tag, cdb_src} !== 46'd0) begin
      n_fail++; $display("FAIL flush_payload: got %h/%h/%h/%h want 0", cdb_preg, cdb_data, cdb_rob_tag, cdb_src);
    end
    reset     = 1'b0;
    req_valid = 3'b000;
    n_out = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cdb_valid === 1'b1) n_out++;
      step;
    end
    n_checks++;
    if (n_out != 0) begin
      n_fail++; $display("FAIL flush_stale: outputs got %0d want 0", n_out);
    end
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 3'b000;
    req_preg       = '0;
    req_data       = '0;
    req_rob_tag    = '0;
    rob_head       = 5'd0;
    mispredict     = 1'b0;
    mispredict_tag = 5'd0;
    test_reset;
    test_single;
    test_round_robin;
`ifdef CDB_BRANCH_PRIORITY_EN
    test_alu_starve;
`endif
    test_squash_wrap;
    test_cdb_kill;
    test_reset_flush;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
